muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer that owns the HI/LO architectural registers for the MIPS core. It accepts MULT/MULTU/DIV/DIVU from the execute stage and iterates a shift-add multiplier or restoring divider over WIDTH cycles. It raises a stall toward fetch/execute on structural hazards (new op while busy) and data hazards (MFHI/MFLO while busy). HI/LO writeback to the register file stays in the existing writeback mux; this block only supplies hi/lo values.

Parameters:
WIDTH, 32, operand width; iteration count per op
DBZ_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
op_valid  input  1  execute stage presents a mul/div op this cycle
op_code  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand
b  input  WIDTH  rt operand
hilo_rd  input  1  MFHI/MFLO in execute this cycle
flush  input  1  abort in-flight op (branch squash)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  op in flight
done  output  1  one-cycle pulse when hi/lo updated by a completing op
dbz  output  1  sticky divide-by-zero flag for last completed divide; cleared on next accept
stall  output  1  combinational hold request to fetch/execute

Behaviour:
- Reset (rst=0, async): state IDLE; hi=0, lo=0, busy=0, done=0, dbz=0, iteration counter=0, internal accum/quotient/remainder=0. stall=0 while in reset.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: op_valid=1 -> latch |a|,|b| (magnitude for signed codes, raw for unsigned), result sign (a^b for quotient/product, a for remainder), counter=0, dbz<=0; go MUL (op 0x) or DIV (op 1x). Divide with b==0 -> go DONE directly: hi<=a, lo<=DBZ_LO, dbz<=1.
- MUL: one shift-add step per cycle, 2*WIDTH-bit accumulator; after WIDTH steps -> FIX.
- DIV: one restoring step per cycle (shift remainder, trial-subtract, set quotient bit); after WIDTH steps -> FIX.
- FIX: apply signs (two's-complement negate), write hi/lo -> DONE. Mul: {hi,lo}=product. Div: lo=quotient, hi=remainder.
- DONE: done=1 for exactly this cycle -> IDLE. A new op_valid in DONE is accepted next cycle (from IDLE), not this one.
- Latency: accept at edge T; hi/lo visible and done=1 at cycle T+WIDTH+2 (34 for WIDTH=32). DBZ path: T+1.
- busy=1 in MUL, DIV, FIX, DONE; 0 in IDLE.
- stall = busy & (op_valid | hilo_rd). Requester holds op/read until stall drops; no queue, no second op accepted while busy.
- hi/lo hold value except at the FIX or DBZ write; never partially updated.
- flush while busy: next edge -> IDLE, hi/lo and dbz unchanged, no done pulse. flush in IDLE with op_valid: op not accepted. flush in DONE: ignored, since hi/lo are already written.
- Signed edge: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (no trap). MULT of most-negative values yields correct 64-bit two's complement.
- rst asserted mid-op: immediate return to reset values, including hi/lo.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 cycles hi=0xFFFFFFFE lo=0x00000001, done 1 cycle, busy low next cycle.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1).
- DIVU a=100 b=0 -> next cycle hi=100 lo=0xFFFFFFFF dbz=1 done=1; following DIV 9/3 clears dbz, lo=3 hi=0.
- Issue DIVU 1000/7, assert hilo_rd at cycle 5 and a second op_valid at cycle 10 -> stall=1 both times until done cycle; held second op is accepted on the cycle after DONE.
- MULTU 5*6 completes (lo=30); start DIVU 50/5, flush at cycle 12 -> state IDLE next cycle, hi=0 lo=30 unchanged, no done pulse.
- Start MULT, drop rst at cycle 8 -> hi=lo=0, busy=0, stall=0 immediately (asynchronous); release rst and run DIVU 0x80000000/0xFFFFFFFF -> lo=0, hi=0x80000000.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - execute-side op/readback bundle for the mul/div sequencer
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_rd;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dbz;
  logic             stall;

  modport master (
    output op_valid, op_code, a, b, hilo_rd, flush,
    input  hi, lo, busy, done, dbz, stall
  );

  modport slave (
    input  op_valid, op_code, a, b, hilo_rd, flush,
    output hi, lo, busy, done, dbz, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module muldiv_seq #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] DBZ_LO = {WIDTH{1'b1}}
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_reg;    // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi;   // product upper half, or partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits shifting out, or dividend in / quotient out
  logic             is_div;
  logic             neg_q;    // negate product / quotient at the end
  logic             neg_r;    // negate remainder at the end
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Operand magnitudes and signs for the op being presented (codes 00/10 are signed)
  always_comb begin
    op_signed = ~bus.op_code[0];
    a_neg     = op_signed & bus.a[WIDTH-1];
    b_neg     = op_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // One shift-add / restoring step plus the final sign fix-up values
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, x_reg} : {(WIDTH+1){1'b0}});
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, x_reg};
    prod_mag = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi : acc_hi;
  end

  // Sequencer FSM: accept, iterate WIDTH steps, fix signs, pulse done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      x_reg  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.op_valid && !bus.flush) begin
            busy_r <= 1'b1;
            cnt    <= '0;
            acc_hi <= '0;
            is_div <= bus.op_code[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (bus.op_code[1]) begin
              x_reg  <= b_mag;
              acc_lo <= a_mag;
              if (bus.b == '0) begin
                // Divide by zero skips iteration entirely and commits at once
                hi_r   <= bus.a;
                lo_r   <= DBZ_LO;
                dbz_r  <= 1'b1;
                done_r <= 1'b1;
                state  <= DONE;
              end else begin
                dbz_r <= 1'b0;
                state <= DIV;
              end
            end else begin
              x_reg  <= a_mag;
              acc_lo <= b_mag;
              dbz_r  <= 1'b0;
              state  <= MUL;
            end
          end
        end
        MUL: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) state <= FIX;
          end
        end
        DIV: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            if (!rem_diff[WIDTH]) begin
              acc_hi <= rem_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= rem_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) state <= FIX;
          end
        end
        FIX: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            if (is_div) begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end else begin
              hi_r <= prod_fix[2*WIDTH-1:WIDTH];
              lo_r <= prod_fix[WIDTH-1:0];
            end
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // hi/lo are already committed here, so a flush has nothing to undo
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.dbz   = dbz_r;
  assign bus.stall = busy_r & (bus.op_valid | bus.hilo_rd);
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;
  localparam int             W      = 32;
  localparam logic [W-1:0]   DBZ_LO = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) bus();

  muldiv_seq #(.WIDTH(W), .DBZ_LO(DBZ_LO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} for one op, straight from MIPS semantics
  function automatic logic [63:0] ref_result(input logic [1:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (code)
      2'd0: r = sa * sb;
      2'd1: r = {32'b0, a} * {32'b0, b};
      2'd2: if (b == 0) r = {a, DBZ_LO}; else r = {32'(sa % sb), 32'(sa / sb)};
      2'd3: if (b == 0) r = {a, DBZ_LO}; else r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Timing model: result commits WIDTH+1 edges after accept, divide-by-zero commits on accept
  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.op_valid && !bus.flush) begin
          m_busy <= 1'b1;
          if (bus.op_code[1] && bus.b == 0) begin
            {m_hi, m_lo} <= ref_result(bus.op_code, bus.a, bus.b);
            m_dbz  <= 1'b1;
            m_done <= 1'b1;
            m_left <= 0;
          end else begin
            m_res  <= ref_result(bus.op_code, bus.a, bus.b);
            m_dbz  <= 1'b0;
            m_left <= W + 1;
          end
        end
      end else if (m_left == 0) begin
        m_busy <= 1'b0;
      end else if (bus.flush) begin
        m_busy <= 1'b0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= m_res;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst === 1'b1 && run_cmp) begin
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("dbz", bus.dbz, m_dbz);
      chk("stall", bus.stall, m_busy & (bus.op_valid | bus.hilo_rd));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int   k;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.a        = a;
    bus.b        = b;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 200) begin
      acc = !m_busy && !bus.flush;
      tick();
      k++;
    end
    bus.op_valid = 1'b0;
    chk("accepted", acc, 1'b1);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 80) begin
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic run_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
    chk("model_pin", ref_result(code, a, b), {exp_hi, exp_lo});
    present(code, a, b);
    wait_done(exp_lat);
    chk("lit_hi", bus.hi, exp_hi);
    chk("lit_lo", bus.lo, exp_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int   c;
    int   ndone;
    logic acc;
    bus.op_valid = 1'b1;
    bus.op_code  = 2'd0;
    bus.a        = 32'd5;
    bus.b        = 32'd5;
    bus.hilo_rd  = 1'b1;
    bus.flush    = 1'b0;

    // Reset state, with requests pending to show stall stays low
    repeat (3) tick();
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.dbz, 0);
    chk("rst_stall", bus.stall, 0);
    bus.op_valid = 1'b0;
    bus.hilo_rd  = 1'b0;
    rst          = 1'b1;
    run_cmp      = 1'b1;
    tick();

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
    tick();
    chk("busy_after_done", bus.busy, 0);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    tick();
    run_op(2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1);
    chk("dbz_set", bus.dbz, 1);
    tick();
    run_op(2'd2, 32'd9, 32'd3, 32'd0, 32'd3, 34);
    chk("dbz_clr", bus.dbz, 0);

    // Hazard stalls during a divide; second op held until after DONE
    tick();
    present(2'd3, 32'd1000, 32'd7);
    c = 1;
    while (c < 5) begin tick(); c++; end
    bus.hilo_rd = 1'b1;
    #1;
    chk("stall_hilo", bus.stall, 1);
    while (c < 10) begin tick(); c++; end
    bus.op_valid = 1'b1;
    bus.op_code  = 2'd1;
    bus.a        = 32'd3;
    bus.b        = 32'd4;
    #1;
    chk("stall_op", bus.stall, 1);
    c = 0;
    while (bus.done !== 1'b1 && c < 60) begin tick(); c++; end
    chk("stall_in_done", bus.stall, 1);
    chk("divu_hi", bus.hi, 32'd6);
    chk("divu_lo", bus.lo, 32'd142);
    tick();
    chk("stall_idle", bus.stall, 0);
    chk("idle_busy", bus.busy, 0);
    tick();
    bus.op_valid = 1'b0;
    bus.hilo_rd  = 1'b0;
    chk("held_accept", bus.busy, 1);
    wait_done(34);
    chk("held_hi", bus.hi, 32'd0);
    chk("held_lo", bus.lo, 32'd12);

    // Flush: ignored in DONE, aborts mid-op, blocks accept in IDLE
    tick();
    run_op(2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 34);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_done_lo", bus.lo, 32'd30);
    chk("flush_done_busy", bus.busy, 0);
    present(2'd3, 32'd50, 32'd5);
    c = 1;
    while (c < 12) begin tick(); c++; end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_hi", bus.hi, 32'd0);
    chk("flush_lo", bus.lo, 32'd30);
    ndone = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    chk("flush_no_done", ndone, 0);
    bus.op_valid = 1'b1;
    bus.op_code  = 2'd1;
    bus.flush    = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("flush_idle_busy", bus.busy, 0);

    // Asynchronous reset mid-op
    tick();
    present(2'd0, 32'd12345, 32'd678);
    c = 1;
    while (c < 8) begin tick(); c++; end
    bus.op_valid = 1'b1;
    bus.hilo_rd  = 1'b1;
    #1;
    chk("pre_rst_stall", bus.stall, 1);
    rst = 1'b0;
    #1;
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_stall", bus.stall, 0);
    tick();
    tick();
    bus.op_valid = 1'b0;
    bus.hilo_rd  = 1'b0;
    rst          = 1'b1;
    tick();
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 34);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34);
    run_op(2'd2, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      if (!bus.op_valid && $urandom_range(0, 3) == 0) begin
        bus.op_valid = 1'b1;
        bus.op_code  = 2'($urandom_range(0, 3));
        bus.a        = pick_operand();
        bus.b        = pick_operand();
      end
      bus.hilo_rd = ($urandom_range(0, 4) == 0);
      bus.flush   = ($urandom_range(0, 40) == 0);
      acc = bus.op_valid && !bus.flush && !m_busy;
      tick();
      if (acc) bus.op_valid = 1'b0;
    end
    bus.op_valid = 1'b0;
    bus.hilo_rd  = 1'b0;
    bus.flush    = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
